// File: rtl/types_pkg.sv
// Shared operation/result types plus seven-segment glyph definitions for the display path.
// Glyphs are active-low, ordered {CG,CF,CE,CD,CC,CB,CA}.
package types_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        ADD          = 3'd0,
        SUB          = 3'd1,
        MUL          = 3'd2,
        LEADING_ONES = 3'd3,
        COUNT_ONES   = 3'd4,
        RESET        = 3'd7
    } opr_mode_t;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;
    localparam seg_t SEG_A     = 7'h08;
    localparam seg_t SEG_d     = 7'h21;
    localparam seg_t SEG_S     = 7'h12;
    localparam seg_t SEG_u     = 7'h63;
    localparam seg_t SEG_b     = 7'h03;
    localparam seg_t SEG_n     = 7'h2B;
    localparam seg_t SEG_U     = 7'h41;
    localparam seg_t SEG_L     = 7'h47;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_C     = 7'h46;
    localparam seg_t SEG_t     = 7'h07;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = SEG_A;
            4'hB: s = SEG_b;
            4'hC: s = SEG_C;
            4'hD: s = SEG_d;
            4'hE: s = SEG_E;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph selection: digits 0..3 show the snapshot value in hex,
// digits 4..7 show the operation mnemonic with digit 7 as the leftmost character.
module seg_glyph_rom
    import types_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic [2:0] dig_idx,
    input  opr_mode_t  mode,
    input  word_t      value,
    output seg_t       seg
);

    logic [3:0][6:0] mnem;
    word_t           upper;

    always_comb begin
        mnem  = {SEG_E, SEG_E, SEG_E, SEG_E};
        upper = value >> {dig_idx[1:0], 2'b00};
        seg   = SEG_BLANK;

        // Element [3] lands on digit 7, so listing characters left to right reads naturally
        case (mode)
            ADD:          mnem = {SEG_A, SEG_d, SEG_d, SEG_BLANK};
            SUB:          mnem = {SEG_S, SEG_u, SEG_b, SEG_BLANK};
            MUL:          mnem = {SEG_n, SEG_n, SEG_U, SEG_L};
            LEADING_ONES: mnem = {SEG_L, SEG_E, SEG_A, SEG_d};
            COUNT_ONES:   mnem = {SEG_C, SEG_n, SEG_t, SEG_BLANK};
            RESET:        mnem = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
            default:      mnem = {SEG_E, SEG_E, SEG_E, SEG_E};
        endcase

        if (dig_idx[2]) begin
            seg = mnem[dig_idx[1:0]];
        end else if (BLANK_LZ && (dig_idx[1:0] != 2'd0) && (upper == '0)) begin
            seg = SEG_BLANK;
        end else begin
            seg = hex_to_seg(upper[3:0]);
        end
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed 8-digit common-anode driver: snapshots mode/result on UPDATE and
// scans the digits with one blanked cycle per digit slot to suppress ghosting.
module seg_display_mux
    import types_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  opr_mode_t  SELECTOR,
    input  word_t      RESULT,
    input  logic       UPDATE,
    output logic [7:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    opr_mode_t  mode_q;
    word_t      value_q;
    logic [CNT_W-1:0] div_cnt;
    logic [2:0] dig_idx;
    seg_t       glyph;

    seg_glyph_rom #(
        .BLANK_LZ (BLANK_LZ)
    ) u_rom (
        .dig_idx (dig_idx),
        .mode    (mode_q),
        .value   (value_q),
        .seg     (glyph)
    );

    // Outputs are registered from the current scan position, so they trail it by one cycle
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            mode_q  <= RESET;
            value_q <= '0;
            div_cnt <= '0;
            dig_idx <= '0;
            AN      <= 8'hFF;
            SEG     <= SEG_BLANK;
        end else begin
            if (UPDATE) begin
                mode_q  <= SELECTOR;
                value_q <= RESULT;
            end
            if (div_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                div_cnt <= '0;
                dig_idx <= dig_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            AN  <= (div_cnt == '0) ? 8'hFF : ~(8'd1 << dig_idx);
            SEG <= glyph;
        end
    end

    assign DP = 1'b1;

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It is the output end of the operation path: it takes the selected operation (`opr_mode_t`) and the 16-bit `word_t` result, and shows them on the display. Digits 3..0 show the result in hex. Digits 7..4 show a mnemonic for the operation. Inputs are snapshotted on a strobe so the display never shows a half-updated value.

## Interface
- `REFRESH_DIV`, default 100_000: clock cycles each digit stays selected, including the blank cycle. Minimum 2.
- `BLANK_LZ`, default 1'b1: when 1, leading zero digits of the result are blanked. Digit 0 is never blanked.

Ports:
- `CLK100MHZ`  in  1: system clock. This is the block's only clock.
- `CPU_RESETN`  in  1: reset, synchronous and active-low.
- `SELECTOR`  in  `opr_mode_t`: operation to display.
- `RESULT`  in  `word_t` (16): value to display.
- `UPDATE`  in  1: single-cycle strobe that captures `SELECTOR` and `RESULT`.
- `AN`  out  8: digit enables, active-low and one-hot.
- `SEG`  out  7: segments ordered {CG,CF,CE,CD,CC,CB,CA}, active-low.
- `DP`  out  1: decimal point, active-low. Held at 1 (off).

## Operation
- **Snapshot registers.** `mode_q` and `value_q` load on any cycle where `UPDATE`=1. Reset loads `mode_q`=RESET and `value_q`=0.
- **Refresh counter.** `div_cnt` counts 0..REFRESH_DIV-1 and then wraps to 0.
- **Digit index.** `dig_idx` is 3 bits and increments when `div_cnt` wraps. It wraps 7→0.
- **Anti-ghosting blank.** While `div_cnt`==0, `AN`=8'hFF. In all other cycles, `AN` has bit `dig_idx` low and all other bits high.
- **Result digits (`dig_idx` 0..3).** Each shows the hex glyph of `value_q[4*i+3:4*i]`.
- **Leading-zero blanking.** With `BLANK_LZ`=1, digit i ≥ 1 is blanked (`SEG`=7'h7F) when `value_q[15:4*i]`==0.
- **Mode digits (`dig_idx` 4..7).** Digit 7 holds the leftmost character. Mnemonics:
  - ADD: "Add"
  - SUB: "Sub"
  - MUL: "nnUL"
  - LEADING_ONES: "LEAd"
  - COUNT_ONES: "Cnt"
  - RESET: "----"
  - Mnemonics shorter than 4 characters are left-justified and padded with blanks on the right.
  - An unlisted encoding shows "EEEE".
- **Glyph encodings.** Required values: 0=7'h40, 1=7'h79, A=7'h08, F=7'h0E, "-"=7'h3F, blank=7'h7F.
- **Snapshot timing.** A snapshot taken mid-scan changes the glyph on the next registered output. There is no wait for a frame boundary.

## Timing
- All outputs are registered. `AN` and `SEG` change 1 cycle after the `div_cnt`/`dig_idx` state that selects them.
- **Reset values:** `AN`=8'hFF, `SEG`=7'h7F, `DP`=1, `div_cnt`=0, `dig_idx`=0.
- **First lit cycle after reset:** the first cycle is blank. `AN`=8'hFE appears on the 2nd clock after `CPU_RESETN` rises.
- **Frame period:** 8·REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-1 cycles.
- **`UPDATE` latency:** with `UPDATE` high at edge N, a digit lit during N+1 shows the new data from edge N+2.
- **`UPDATE` and reset together:** reset wins.
- **Reset asserted mid-scan:** takes effect at the next clock edge and returns every register to its reset value.

## Structure
- Add to `types_pkg`:
  - `seg_t` (7-bit)
  - glyph constants: `SEG_BLANK`, `SEG_DASH`, letters `A,d,S,u,b,n,U,L,E,C,t`
  - `function hex_to_seg(logic [3:0])`
- Keep `opr_mode_t` and `word_t` in `types_pkg` unchanged.
- Sub-module `seg_glyph_rom`: a combinational map from (`dig_idx`, `mode_q`, `value_q`, `BLANK_LZ`) to `seg_t`.
- The top-level block holds the counters, snapshot registers and output registers.

## Test plan
All scenarios use `REFRESH_DIV`=4.
- **Reset state:** hold `CPU_RESETN`=0 for 3 cycles → `AN`=8'hFF, `SEG`=7'h7F, `DP`=1 each cycle. After release, `AN` is 8'hFF for 1 cycle, then 8'hFE with `SEG`=7'h40.
- **Hex digits:** `UPDATE` pulse with `RESULT`=16'hAF10 and `BLANK_LZ`=1 → digits 0..3 show `SEG` 7'h40, 7'h79, 7'h0E, 7'h08 in turn.
- **Leading zeros:** `RESULT`=16'h0001 → digit 0=7'h79, digits 1..3=7'h7F. Repeat with `BLANK_LZ`=0 → digits 1..3=7'h40.
- **Anti-ghosting:** over 2 full frames, `AN`=8'hFF at every 4th cycle. `AN` is never zero-hot or multi-hot, and the low bit rotates 0→7→0.
- **Mode mnemonics:** `SELECTOR`=SUB then RESET, each with `UPDATE` → digits 7..4 show "Sub " then "----" (7'h3F ×4). `SELECTOR` changing without `UPDATE` leaves the display unchanged.
- **Mid-operation events:** `UPDATE` asserted in the same cycle as `CPU_RESETN`=0 → the snapshot stays at reset values. `UPDATE` while digit 2 is lit → the new nibble is visible 2 cycles later.
